// File: rtl/sha_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha_pad_ctrl
// Brief    : Mux-select sequencer for SHA-512 style padding: message, pad,
//            zero fill and length word aligned to the last block slot.
// Revision : 1.0
// ============================================================================
module sha_pad_ctrl #(
    parameter int W         = 64,
    parameter int BLK_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         pad_pkt,
    output logic                         zero_pkt,
    output logic                         mgln_pkt,
    output logic [W-1:0]                 msg_len,
    output logic [$clog2(BLK_WORDS)-1:0] word_idx,
    output logic                         blk_last,
    output logic                         busy,
    output logic                         done
);

    localparam int             IW          = $clog2(BLK_WORDS);
    localparam logic [IW-1:0]  C_IDX_LAST  = IW'(BLK_WORDS - 1);
    localparam logic [W-1:0]   C_WORD_BITS = W'(W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MSG  = 3'd1,
        S_PAD  = 3'd2,
        S_ZERO = 3'd3,
        S_LEN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_msg_len;
    logic [IW-1:0] r_word_idx;
    logic [IW-1:0] w_idx_inc;
    logic          w_xfer;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        pad_pkt     = 1'b0;
        zero_pkt    = 1'b0;
        mgln_pkt    = 1'b0;
        done        = 1'b0;
        w_idx_inc   = r_word_idx + IW'(1);
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_MSG;
            end
            S_MSG: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                if (in_valid && out_ready && in_last) w_state_nxt = S_PAD;
            end
            S_PAD: begin
                out_valid = 1'b1;
                pad_pkt   = 1'b1;
                // A pad in the last slot leaves no room: a whole extra block follows.
                if (out_ready) begin
                    w_state_nxt = (w_idx_inc == C_IDX_LAST) ? S_LEN : S_ZERO;
                end
            end
            S_ZERO: begin
                out_valid = 1'b1;
                zero_pkt  = 1'b1;
                if (out_ready && (w_idx_inc == C_IDX_LAST)) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                out_valid = 1'b1;
                mgln_pkt  = 1'b1;
                if (out_ready) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_xfer   = out_valid & out_ready;
    assign busy     = (r_state != S_IDLE);
    assign blk_last = out_valid && (r_word_idx == C_IDX_LAST);
    assign msg_len  = r_msg_len;
    assign word_idx = r_word_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_msg_len  <= '0;
            r_word_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msg_len  <= '0;
                        r_word_idx <= '0;
                    end
                end
                S_MSG: begin
                    if (w_xfer) begin
                        r_msg_len  <= r_msg_len + C_WORD_BITS;
                        r_word_idx <= w_idx_inc;
                    end
                end
                S_PAD, S_ZERO: begin
                    if (w_xfer) r_word_idx <= w_idx_inc;
                end
                S_LEN: begin
                    if (w_xfer) r_word_idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_pad_ctrl
// Brief    : Table-driven checker for sha_pad_ctrl message/pad/zero/len order.
// Revision : 1.0
// ============================================================================
module tb_sha_pad_ctrl;

    localparam int W   = 64;
    localparam int BLK = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        pad_pkt;
    logic        zero_pkt;
    logic        mgln_pkt;
    logic [63:0] msg_len;
    logic [3:0]  word_idx;
    logic        blk_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    sha_pad_ctrl #(.W(W), .BLK_WORDS(BLK)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pad_pkt   (pad_pkt),
        .zero_pkt  (zero_pkt),
        .mgln_pkt  (mgln_pkt),
        .msg_len   (msg_len),
        .word_idx  (word_idx),
        .blk_last  (blk_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n_words;
        bit          toggle;
        int          pad_slot;
        int          zero_cnt;
        logic [63:0] exp_len;
        int          xfers;
        int          bl_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd0);
        chk({tag, "_selects"},   {61'd0, pad_pkt, zero_pkt, mgln_pkt}, 64'd0);
        chk({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_blk_last"},  {63'd0, blk_last}, 64'd0);
        chk({tag, "_word_idx"},  {60'd0, word_idx}, 64'd0);
    endtask

    // abort_at >= 0: assert rst when about to make transfer number abort_at.
    task automatic run_msg(input vec_t v, input int abort_at);
        int k, cyc, pad_seen, zero_seen, bl_seen, kind;
        logic rdy;
        logic [3:0] eidx;
        logic [63:0] elen;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #1 chk("idle_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = v.toggle;   // start while busy must be ignored
        k = 0; cyc = 0; pad_seen = -1; zero_seen = 0; bl_seen = 0;
        while (k < v.xfers && cyc < 400) begin
            rdy       = v.toggle ? (cyc % 2 == 1) : 1'b1;
            out_ready = rdy;
            in_valid  = 1'b1;
            in_last   = (k >= v.n_words - 1);
            #1;
            eidx = 4'(k % BLK);
            if (k < v.n_words)       kind = 0;
            else if (k == v.n_words) kind = 1;
            else if (k == v.xfers-1) kind = 3;
            else                     kind = 2;
            if (k == abort_at) begin
                chk("pre_rst_zero", {59'd0, zero_pkt, word_idx}, {59'd0, 1'b1, 4'd7});
                start = 1'b0; in_valid = 1'b0; rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1 chk_idle("post_rst");
                chk("post_rst_msg_len", msg_len, 64'd0);
                return;
            end
            elen = 64'((k < v.n_words ? k : v.n_words) * W);
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("in_ready", {63'd0, in_ready}, {63'd0, (kind == 0) ? rdy : 1'b0});
            chk("selects", {61'd0, pad_pkt, zero_pkt, mgln_pkt},
                {61'd0, kind == 1, kind == 2, kind == 3});
            chk("word_idx", {60'd0, word_idx}, {60'd0, eidx});
            chk("blk_last", {63'd0, blk_last}, {63'd0, eidx == 4'd15});
            chk("msg_len", msg_len, elen);
            chk("busy_done", {62'd0, busy, done}, 64'd2);
            if (out_valid && out_ready) begin
                if (pad_pkt)  pad_seen = int'(word_idx);
                if (zero_pkt) zero_seen++;
                if (blk_last) bl_seen++;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("xfer_budget", {63'd0, cyc >= 400}, 64'd0);
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("done_pulse", {61'd0, done, busy, out_valid}, 64'd6);
        chk("len_word", msg_len, v.exp_len);
        @(negedge clk);
        #1 chk_idle("after_done");
        chk("len_hold", msg_len, v.exp_len);
        chk("pad_slot", 64'(pad_seen), 64'(v.pad_slot));
        chk("zero_cnt", 64'(zero_seen), 64'(v.zero_cnt));
        chk("blk_last_cnt", 64'(bl_seen), 64'(v.bl_cnt));
    endtask

    initial begin
        vecs[0] = '{n_words: 3,  toggle: 1'b0, pad_slot: 3,  zero_cnt: 11, exp_len: 64'hC0,  xfers: 16, bl_cnt: 1};
        vecs[1] = '{n_words: 14, toggle: 1'b0, pad_slot: 14, zero_cnt: 0,  exp_len: 64'h380, xfers: 16, bl_cnt: 1};
        vecs[2] = '{n_words: 15, toggle: 1'b0, pad_slot: 15, zero_cnt: 15, exp_len: 64'd960, xfers: 32, bl_cnt: 2};
        vecs[3] = '{n_words: 16, toggle: 1'b0, pad_slot: 0,  zero_cnt: 14, exp_len: 64'h400, xfers: 32, bl_cnt: 2};
        vecs[4] = '{n_words: 3,  toggle: 1'b1, pad_slot: 3,  zero_cnt: 11, exp_len: 64'hC0,  xfers: 16, bl_cnt: 1};
        vecs[5] = '{n_words: 1,  toggle: 1'b0, pad_slot: 1,  zero_cnt: 13, exp_len: 64'd64,  xfers: 16, bl_cnt: 1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk_idle("reset");
        chk("reset_msg_len", msg_len, 64'd0);

        for (int i = 0; i < 6; i++) begin
            // Reset mid-ZERO (idx 7) of a 3-word message before the last vector.
            if (i == 5) run_msg(vecs[0], 7);
            run_msg(vecs[i], -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
